// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 hex keypad scanner with synchronizer, debouncer and
// a 32-bit shift-in entry register (newest digit in the low nibble).
module keypad_scan_entry #(
  parameter int SCAN_BITS       = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [31:0] DATA,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam logic [1:0] SCAN         = 2'd0;
  localparam logic [1:0] DEBOUNCE     = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           state;
  logic [3:0]           row_m;
  logic [3:0]           row_s;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [DW-1:0]        deb_cnt;
  logic [1:0]           c;
  logic [3:0]           pat;
  logic [1:0]           r_cap;
  logic [1:0]           low_row;
  logic [3:0]           code;

  // Hex legend of the keypad, indexed by row and column.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] cc);
    logic [3:0] k;
    case ({r, cc})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign col  = ~(4'b0001 << c);
  assign code = key_map(r_cap, c);

  // Lowest-indexed active-low row wins when several rows are pulled down.
  always_comb begin
    low_row = 2'd3;
    if (!row_s[0])      low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
  end

  // Two-flop synchronizer for the asynchronous row returns.
  always_ff @(posedge clk1) begin
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Scan / debounce / release FSM and the entry register.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= SCAN;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      c         <= 2'd0;
      pat       <= '1;
      r_cap     <= 2'd0;
      DATA      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          scan_cnt <= scan_cnt + 1'b1;
          if (scan_cnt == '1) begin
            if (row_s != 4'hF) begin
              pat     <= row_s;
              r_cap   <= low_row;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              c <= c + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (row_s == pat) begin
            if (deb_cnt == DEB_LAST) begin
              key_valid <= 1'b1;
              key_code  <= code;
              DATA      <= {DATA[27:0], code};
              deb_cnt   <= '0;
              state     <= WAIT_RELEASE;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            state    <= SCAN;
            c        <= c + 2'd1;
            scan_cnt <= '0;
            deb_cnt  <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (row_s == 4'hF) begin
            if (deb_cnt == DEB_LAST) begin
              state    <= SCAN;
              c        <= c + 2'd1;
              scan_cnt <= '0;
              deb_cnt  <= '0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: begin
          state    <= SCAN;
          scan_cnt <= '0;
          deb_cnt  <= '0;
        end
      endcase
      // Clear overrides a coincident commit's shift; key_code/key_valid still update.
      if (clear) DATA <= '0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Self-checking bench for keypad_scan_entry with a keypad switch model and
// a scoreboard of expected {key_code, DATA} per key_valid pulse.
module tb_keypad_scan_entry;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] DATA;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] press_mask = '0;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[9];

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic        prev_kv = 1'b0;
  logic [31:0] model_data = '0;

  keypad_scan_entry #(.SCAN_BITS(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk1(clk1), .rst(rst), .row(row), .col(col), .clear(clear),
    .DATA(DATA), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk1 = ~clk1;

  // Switch matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (press_mask[r*4+cc] && !col[cc]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation.
  always @(negedge clk1) begin
    if (key_valid) begin
      pulse_cnt++;
      check("kv_not_consecutive", {31'd0, prev_kv}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_key_code", {28'd0, key_code}, {28'd0, e.code});
        check("sb_DATA", DATA, e.data);
      end
    end
    prev_kv = key_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] kbit(input int r, input int cc);
    return 16'(1) << (r*4 + cc);
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic expect_key(input logic [3:0] code, input logic clr);
    exp_t e;
    model_data = clr ? 32'd0 : {model_data[27:0], code};
    e.code = code;
    e.data = model_data;
    sb.push_back(e);
  endtask

  task automatic wait_pulse(input string name);
    int start;
    int n;
    start = pulse_cnt;
    n = 0;
    while (pulse_cnt == start && n < 300) begin
      tick();
      n++;
    end
    if (pulse_cnt == start) check(name, 32'd0, 32'd1);
  endtask

  task automatic press(input logic [15:0] mask, input logic [3:0] code);
    expect_key(code, 1'b0);
    press_mask = mask;
    wait_pulse("press_timeout");
    repeat (5) tick();
    press_mask = '0;
    repeat (20) tick();
  endtask

  // Align to the edge at which col first becomes target (dwell counter at 0).
  task automatic align_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 100) begin tick(); n++; end
    n = 0;
    while (col != target && n < 100) begin tick(); n++; end
    check("align_col", {28'd0, col}, {28'd0, target});
  endtask

  initial begin
    logic [3:0] exp_cols [4];
    int p0;
    int n;

    exp_cols[0] = 4'b1110; exp_cols[1] = 4'b1101;
    exp_cols[2] = 4'b1011; exp_cols[3] = 4'b0111;

    tbl[0] = '{0, 0, 4'h1}; tbl[1] = '{0, 1, 4'h2}; tbl[2] = '{0, 2, 4'h3};
    tbl[3] = '{1, 0, 4'h4}; tbl[4] = '{1, 1, 4'h5}; tbl[5] = '{1, 2, 4'h6};
    tbl[6] = '{2, 0, 4'h7}; tbl[7] = '{2, 1, 4'h8}; tbl[8] = '{2, 2, 4'h9};

    // 1. Reset values and column rotation
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_DATA", DATA, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk1);
      check("scan_rotation", {28'd0, col}, {28'd0, exp_cols[i/4]});
    end

    // 2. Single key 5 held 200 cycles
    tick();
    p0 = pulse_cnt;
    expect_key(4'h5, 1'b0);
    press_mask = kbit(1, 1);
    repeat (200) tick();
    check("hold_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("hold_key_code", {28'd0, key_code}, 32'h5);
    check("hold_DATA", DATA, 32'h5);
    check("hold_col_frozen", {28'd0, col}, 32'hD);
    press_mask = '0;
    n = 0;
    while (col == 4'b1101 && n < 50) begin tick(); n++; end
    check("release_edges", 32'(n), 32'd10);
    check("release_next_col", {28'd0, col}, 32'hB);
    repeat (10) tick();

    // 3. Digit sequence from the table
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) press(kbit(tbl[i].r, tbl[i].c), tbl[i].code);
    check("seq_DATA8", DATA, 32'h12345678);
    press(kbit(tbl[8].r, tbl[8].c), tbl[8].code);
    check("seq_DATA9", DATA, 32'h23456789);
    check("seq_pulses", 32'(pulse_cnt - p0), 32'd9);

    // 4. Bounce: key 1 pressed for 3 cycles only
    p0 = pulse_cnt;
    align_col(4'b1110);
    press_mask = kbit(0, 0);
    repeat (3) tick();
    press_mask = '0;
    n = 0;
    while (col == 4'b1110 && n < 50) begin tick(); n++; end
    check("bounce_next_col", {28'd0, col}, 32'hD);
    repeat (40) tick();
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_DATA", DATA, 32'h23456789);

    // 5. Clear, then clear on the exact commit cycle of key A
    clear = 1'b1; tick(); clear = 1'b0;
    model_data = '0;
    press(kbit(3, 3), 4'hD);
    check("clear_pre_DATA", DATA, 32'hD);
    clear = 1'b1; tick(); clear = 1'b0;
    model_data = '0;
    @(negedge clk1);
    check("clear_DATA", DATA, 32'd0);
    align_col(4'b0111);
    expect_key(4'hA, 1'b1);
    press_mask = kbit(0, 3);
    repeat (11) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk1);
    check("clrcommit_key_valid", {31'd0, key_valid}, 32'd1);
    check("clrcommit_key_code", {28'd0, key_code}, 32'hA);
    check("clrcommit_DATA", DATA, 32'd0);
    press_mask = '0;
    repeat (25) tick();

    // 6. Multi-row press, then reset during debounce
    press(kbit(0, 0) | kbit(2, 0), 4'h1);
    check("multirow_key_code", {28'd0, key_code}, 32'h1);
    check("multirow_DATA", DATA, 32'h1);
    p0 = pulse_cnt;
    align_col(4'b1110);
    press_mask = kbit(2, 0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    press_mask = '0;
    @(negedge clk1);
    check("midrst_col", {28'd0, col}, 32'hE);
    check("midrst_DATA", DATA, 32'd0);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_key_code", {28'd0, key_code}, 32'd0);
    tick();
    rst = 1'b0;
    model_data = '0;
    repeat (40) tick();
    check("midrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
